// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the multiport register file.
package regfile_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultDepth = 32;
  localparam int unsigned DefaultNRead = 2;
  localparam int unsigned ZeroRegIdx   = 0;

  typedef enum logic [1:0] {
    CntHold,
    CntInc,
    CntDec
  } cnt_op_e;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// Read/write/reserve bus of the register file; master = datapath, slave = register file.
interface regfile_multiport_if
  import regfile_pkg::*;
#(
  parameter int unsigned Width = DefaultWidth,
  parameter int unsigned Depth = DefaultDepth,
  parameter int unsigned NRead = DefaultNRead
) ();
  localparam int unsigned Aw = addr_width(Depth);

  logic [NRead*Aw-1:0]    read_register;
  logic [NRead*Width-1:0] read_data;
  logic [NRead-1:0]       read_busy;
  logic [Aw-1:0]          write_register;
  logic [Width-1:0]       write_data;
  logic                   reg_write;
  logic                   reserve;
  logic [Aw-1:0]          reserve_register;
  logic [Aw:0]            pending_count;

  modport master (
    output read_register, write_register, write_data, reg_write, reserve, reserve_register,
    input  read_data, read_busy, pending_count
  );

  modport slave (
    input  read_register, write_register, write_data, reg_write, reserve, reserve_register,
    output read_data, read_busy, pending_count
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for RAW hazard detection, plus a running popcount.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned Depth   = DefaultDepth,
  parameter bit          ZeroReg = 1'b1,
  localparam int unsigned Aw     = addr_width(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_i,
  input  logic [Aw-1:0]    set_addr_i,
  input  logic             clr_i,
  input  logic [Aw-1:0]    clr_addr_i,
  output logic [Depth-1:0] pending_o,
  output logic [Aw:0]      count_o
);

  logic [Depth-1:0] pending_q, pending_d, set_mask, clr_mask;
  logic [Aw:0]      count_q, count_d;
  logic             set_eff, set_new, clr_real;
  cnt_op_e          cnt_op;

  always_comb begin
    set_eff   = set_i && !(ZeroReg && (set_addr_i == Aw'(ZeroRegIdx)));
    set_mask  = set_eff ? (Depth'(1) << set_addr_i) : '0;
    clr_mask  = clr_i ? (Depth'(1) << clr_addr_i) : '0;
    // Set is applied after clear so a new reservation supersedes a same-cycle writeback.
    pending_d = (pending_q & ~clr_mask) | set_mask;
    set_new   = set_eff && !pending_q[set_addr_i];
    clr_real  = clr_i && pending_q[clr_addr_i] && !(set_eff && (set_addr_i == clr_addr_i));

    cnt_op = CntHold;
    if (set_new && !clr_real) begin
      cnt_op = CntInc;
    end else if (clr_real && !set_new) begin
      cnt_op = CntDec;
    end

    case (cnt_op)
      CntInc:  count_d = count_q + {{Aw{1'b0}}, 1'b1};
      CntDec:  count_d = count_q - {{Aw{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign pending_o = pending_q;
  assign count_o   = count_q;

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file: storage array, NRead combinational read ports with
// optional write bypass, and a pending scoreboard for hazard detection.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int unsigned Width   = DefaultWidth,
  parameter int unsigned Depth   = DefaultDepth,
  parameter int unsigned NRead   = DefaultNRead,
  parameter bit          ZeroReg = 1'b1,
  parameter bit          Bypass  = 1'b1
) (
  input logic               clk_i,
  input logic               rst_i,
  regfile_multiport_if.slave bus
);
  localparam int unsigned Aw = addr_width(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata [NRead];
  logic [NRead-1:0] rbusy;
  logic [Depth-1:0] pending;
  logic             wr_en;

  assign wr_en = bus.reg_write && !(ZeroReg && (bus.write_register == Aw'(ZeroRegIdx)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[bus.write_register] <= bus.write_data;
    end
  end

  for (genvar gi = 0; gi < NRead; gi++) begin : g_read
    logic [Aw-1:0] addr;
    logic          is_zero;
    logic          fwd;

    assign addr      = bus.read_register[gi*Aw +: Aw];
    assign is_zero   = ZeroReg && (addr == Aw'(ZeroRegIdx));
    assign fwd       = Bypass && wr_en && (bus.write_register == addr);
    assign rdata[gi] = fwd ? bus.write_data : (is_zero ? '0 : mem_q[addr]);
    // A forwarded write resolves the hazard in the same cycle.
    assign rbusy[gi] = pending[addr] && !fwd;
  end

  always_comb begin
    bus.read_data = '0;
    for (int unsigned i = 0; i < NRead; i++) begin
      bus.read_data[i*Width +: Width] = rdata[i];
    end
  end

  assign bus.read_busy = rbusy;

  regfile_scoreboard #(
    .Depth   (Depth),
    .ZeroReg (ZeroReg)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_i      (bus.reserve),
    .set_addr_i (bus.reserve_register),
    .clr_i      (bus.reg_write),
    .clr_addr_i (bus.write_register),
    .pending_o  (pending),
    .count_o    (bus.pending_count)
  );

endmodule
